// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO family.
// Width functions and the read-mode encoding.
package sync_fifo_pkg;

    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_flags.sv
// Occupancy counter, status flags and sticky error flags.
// Shared by every FIFO variant that needs count-derived status.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int CW        = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          wr_acc,
    output logic          rd_acc,
    output logic [CW-1:0] count,
    output logic          wr_full,
    output logic          wr_almost_full,
    output logic          wr_overflow,
    output logic          rd_empty,
    output logic          rd_almost_empty,
    output logic          rd_underflow
);

    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    assign wr_full         = (count_q == CW'(DEPTH));
    assign rd_empty        = (count_q == '0);
    assign wr_almost_full  = (count_q >= CW'(AF_THRESH));
    assign rd_almost_empty = (count_q <= CW'(AE_THRESH));
    assign wr_acc          = wr_en & ~wr_full;
    assign rd_acc          = rd_en & ~rd_empty;

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q | (wr_en & wr_full);
        underflow_d = underflow_q | (rd_en & rd_empty);
        unique case (1'b1)
            wr_acc & ~rd_acc: count_d = count_q + CW'(1);
            rd_acc & ~wr_acc: count_d = count_q - CW'(1);
            default:          count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count        = count_q;
    assign wr_overflow  = overflow_q;
    assign rd_underflow = underflow_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO: any depth, STD or FWFT read, programmable
// almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DWIDTH    = 64,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DWIDTH-1:0]           wr_data,
    output logic                        wr_full,
    output logic                        wr_almost_full,
    output logic                        wr_overflow,
    input  logic                        rd_en,
    output logic [DWIDTH-1:0]           rd_data,
    output logic                        rd_empty,
    output logic                        rd_almost_empty,
    output logic                        rd_underflow,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam bit IS_FWFT = (FWFT == int'(RD_FWFT));

    if (DWIDTH < 1 || DEPTH < 2 || (FWFT != 0 && FWFT != 1) ||
        AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
        $error("sync_fifo_prog: illegal parameter combination");
    end

    logic              wr_acc, rd_acc;
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DWIDTH-1:0] rd_data_q, rd_data_d;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    sync_fifo_flags #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH),
        .CW        (CW)
    ) u_flags (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .wr_acc          (wr_acc),
        .rd_acc          (rd_acc),
        .count           (count),
        .wr_full         (wr_full),
        .wr_almost_full  (wr_almost_full),
        .wr_overflow     (wr_overflow),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_underflow    (rd_underflow)
    );

    always_comb begin
        wr_ptr_d  = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is deliberately not reset; pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    if (IS_FWFT) begin : g_fwft
        assign rd_data = rd_empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
        assign rd_data = rd_data_q;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: a STD instance (depth 5)
// against a queue scoreboard, plus a small FWFT instance.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = '0, rd_data;
    logic       wr_full, wr_af, wr_ovf, rd_empty, rd_ae, rd_udf;
    logic [2:0] count;

    sync_fifo_prog #(
        .DWIDTH(8), .DEPTH(5), .FWFT(0), .AF_THRESH(3), .AE_THRESH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .wr_almost_full(wr_af), .wr_overflow(wr_ovf),
        .rd_en(rd_en), .rd_data(rd_data),
        .rd_empty(rd_empty), .rd_almost_empty(rd_ae),
        .rd_underflow(rd_udf), .count(count)
    );

    logic       f_rst = 1'b0;
    logic       f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_wr_data = '0, f_rd_data;
    logic       f_full, f_af, f_ovf, f_empty, f_ae, f_udf;
    logic [2:0] f_count;

    sync_fifo_prog #(
        .DWIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)
    ) dut_fwft (
        .clk(clk), .rst(f_rst),
        .wr_en(f_wr_en), .wr_data(f_wr_data),
        .wr_full(f_full), .wr_almost_full(f_af), .wr_overflow(f_ovf),
        .rd_en(f_rd_en), .rd_data(f_rd_data),
        .rd_empty(f_empty), .rd_almost_empty(f_ae),
        .rd_underflow(f_udf), .count(f_count)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];
    logic [7:0] m_rd;
    logic       m_ovf, m_udf;
    bit         m_pop;

    // One clock of stimulus on the STD instance; scoreboard tracks the result.
    task automatic drive(input logic we, input logic [7:0] wd,
                         input logic re);
        int sz;
        sz = sb.size();
        wr_en = we; wr_data = wd; rd_en = re;
        m_pop = re && sz != 0;
        if (we && sz == 5) m_ovf = 1'b1;
        if (re && sz == 0) m_udf = 1'b1;
        if (m_pop) m_rd = sb.pop_front();
        if (we && sz != 5) sb.push_back(wd);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({count, rd_empty, wr_full, rd_ae, wr_af} !== 7'b000_1010) begin
            n_fail++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0",
                     count, rd_empty, wr_full, rd_ae, wr_af);
        end
        n_chk++;
        if ({wr_ovf, rd_udf, rd_data} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_err_data: got ovf=%b udf=%b rd=%h want 0 0 00",
                     wr_ovf, rd_udf, rd_data);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            n_chk++;
            if (count !== 3'(i) || wr_af !== (i >= 3) || rd_empty !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_%0d: got cnt=%0d af=%b e=%b want %0d %b 0",
                         i, count, wr_af, rd_empty, i, (i >= 3));
            end
        end
        n_chk++;
        if (wr_full !== 1'b1 || wr_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b ovf=%b want 1 0", wr_full, wr_ovf);
        end
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        n_chk++;
        if (wr_ovf !== 1'b1 || count !== 3'd5 || wr_full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_overflow: got ovf=%b cnt=%0d full=%b want 1 5 1",
                     wr_ovf, count, wr_full);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_chk++;
            if (rd_data !== m_rd || rd_data !== 8'(i) || count !== 3'(5 - i)) begin
                n_fail++;
                $display("FAIL drain_%0d: got rd=%h cnt=%0d want %h %0d",
                         i, rd_data, count, m_rd, 5 - i);
            end
        end
        n_chk++;
        if (rd_empty !== 1'b1 || rd_udf !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got e=%b udf=%b want 1 0", rd_empty, rd_udf);
        end
        drive(1'b0, 8'h00, 1'b1);
        n_chk++;
        if (rd_udf !== 1'b1 || rd_data !== 8'h05 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_underflow: got udf=%b rd=%h cnt=%0d want 1 05 0",
                     rd_udf, rd_data, count);
        end
    endtask

    task automatic test_wrap();
        int max_cnt;
        max_cnt = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'h10 + 8'(i), i >= 2);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (m_pop) begin
                n_chk++;
                if (rd_data !== m_rd) begin
                    n_fail++;
                    $display("FAIL wrap_order_%0d: got %h want %h", i, rd_data, m_rd);
                end
            end
            if (i >= 2) begin
                n_chk++;
                if (count !== 3'd2) begin
                    n_fail++;
                    $display("FAIL wrap_cnt_hold_%0d: got %0d want 2", i, count);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_chk++;
            if (rd_data !== m_rd) begin
                n_fail++;
                $display("FAIL wrap_tail_%0d: got %h want %h", i, rd_data, m_rd);
            end
        end
        n_chk++;
        if (m_rd !== 8'h1B || rd_empty !== 1'b1 || max_cnt > 5) begin
            n_fail++;
            $display("FAIL wrap_end: got last=%h e=%b max=%0d want 1b 1 <=5",
                     m_rd, rd_empty, max_cnt);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h20 + 8'(i), 1'b0);
        drive(1'b1, 8'hEE, 1'b1);
        n_chk++;
        if (count !== 3'd4 || rd_data !== 8'h20 || wr_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_full: got cnt=%0d rd=%h ovf=%b want 4 20 1",
                     count, rd_data, wr_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            n_chk++;
            if (rd_data !== m_rd || rd_data === 8'hEE) begin
                n_fail++;
                $display("FAIL simul_drain_%0d: got %h want %h", i, rd_data, m_rd);
            end
        end
        drive(1'b1, 8'h77, 1'b1);
        n_chk++;
        if (count !== 3'd1 || rd_udf !== 1'b1 || rd_data !== 8'h24) begin
            n_fail++;
            $display("FAIL simul_empty: got cnt=%0d udf=%b rd=%h want 1 1 24",
                     count, rd_udf, rd_data);
        end
        drive(1'b0, 8'h00, 1'b1);
        n_chk++;
        if (rd_data !== 8'h77 || rd_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_readback: got rd=%h e=%b want 77 1", rd_data, rd_empty);
        end
    endtask

    task automatic test_fwft();
        f_rst = 1'b1;
        @(posedge clk); #1;
        f_rst = 1'b0;
        n_chk++;
        if (f_empty !== 1'b1 || f_count !== 3'd0) begin
            n_fail++;
            $display("FAIL fwft_reset: got e=%b cnt=%0d want 1 0", f_empty, f_count);
        end
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        n_chk++;
        if (f_empty !== 1'b0 || f_rd_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL fwft_show: got e=%b rd=%h want 0 a5", f_empty, f_rd_data);
        end
        f_wr_en = 1'b1; f_wr_data = 8'h5A;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        n_chk++;
        if (f_rd_data !== 8'hA5 || f_count !== 3'd2) begin
            n_fail++;
            $display("FAIL fwft_hold: got rd=%h cnt=%0d want a5 2", f_rd_data, f_count);
        end
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        n_chk++;
        if (f_empty !== 1'b0 || f_rd_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL fwft_pop: got e=%b rd=%h want 0 5a", f_empty, f_rd_data);
        end
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        n_chk++;
        if (f_empty !== 1'b1 || f_udf !== 1'b0 || f_count !== 3'd0) begin
            n_fail++;
            $display("FAIL fwft_empty: got e=%b udf=%b cnt=%0d want 1 0 0",
                     f_empty, f_udf, f_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        n_chk++;
        if (count !== 3'd3 || wr_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got cnt=%0d ovf=%b want 3 1", count, wr_ovf);
        end
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        sb.delete();
        m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
        n_chk++;
        if ({count, rd_empty, wr_ovf, rd_udf, rd_data} !== {3'd0, 3'b100, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_reset: got cnt=%0d e=%b ovf=%b udf=%b rd=%h want 0 1 0 0 00",
                     count, rd_empty, wr_ovf, rd_udf, rd_data);
        end
        drive(1'b0, 8'h00, 1'b0);
        n_chk++;
        if (count !== 3'd0 || rd_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_write_ignored: got cnt=%0d e=%b want 0 1", count, rd_empty);
        end
        drive(1'b1, 8'h42, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        n_chk++;
        if (rd_data !== 8'h42) begin
            n_fail++;
            $display("FAIL mid_after: got %h want 42", rd_data);
        end
    endtask

    initial begin
        m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock FIFO generalising the team's async FIFO. Adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It is the default buffering element wherever producer and consumer share one clock domain, e.g. in front of packet formatters and width converters.

Parameters:
DWIDTH, 64, data word width in bits (>=1)
DEPTH, 16, storage capacity in words; any value >=2, not restricted to powers of two
FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
AF_THRESH, DEPTH-2, wr_almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, rd_almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  in  1  single clock; all logic on the rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  write request
wr_data  in  DWIDTH  write data
wr_full  out  1  count == DEPTH
wr_almost_full  out  1  count >= AF_THRESH
wr_overflow  out  1  sticky: a write was attempted while full
rd_en  in  1  read request / pop
rd_data  out  DWIDTH  read data
rd_empty  out  1  no word available
rd_almost_empty  out  1  count <= AE_THRESH
rd_underflow  out  1  sticky: a read was attempted while empty
count  out  $clog2(DEPTH+1)  words currently stored

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Values after a reset cycle: count=0, rd_empty=1, wr_full=0, rd_almost_empty=1, wr_almost_full=0, wr_overflow=0, rd_underflow=0, rd_data=0, write/read pointers=0.
- Memory contents are not cleared by reset. Old contents are unreachable after reset.
- Write acceptance: wr_acc = wr_en & ~wr_full, using the flags as they stand this cycle.
- Read acceptance: rd_acc = rd_en & ~rd_empty, using the flags as they stand this cycle.
- Rejected requests have no effect on storage, pointers, count or rd_data.
- Pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0 with explicit compare, not modulo-2^n.
- count updates at the next edge:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- Flags: rd_empty, wr_full, wr_almost_full and rd_almost_empty are pure functions of registered count, so they change the cycle after the causing event.
- Full with simultaneous wr_en and rd_en: write rejected, read accepted; count goes DEPTH to DEPTH-1.
- Empty with simultaneous wr_en and rd_en: read rejected, write accepted; count goes 0 to 1.
- Standard mode (FWFT=0):
  - rd_data is registered; it shows the popped word on the cycle after rd_acc.
  - rd_data holds its value otherwise.
  - Write-to-rd_empty-deassert latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rd_data continuously shows the head word whenever rd_empty=0; rd_en pops it.
  - The next word, or rd_empty=1, appears the following cycle.
  - Write-to-visible latency is 1 cycle.
  - rd_data is don't-care when rd_empty=1; the bench must not check it.
- Error flags:
  - wr_overflow sets on wr_en & wr_full.
  - rd_underflow sets on rd_en & rd_empty.
  - Both stay set until rst.
- Elaboration: an illegal parameter combination raises $error at elaboration.

Decomposition:
- Package sync_fifo_pkg:
  - function cnt_width(depth) returning $clog2(depth+1)
  - function ptr_width(depth) returning $clog2(depth), minimum 1
  - localparam typedef for the read-mode enum: STD=0, FWFT=1
- One sub-module, sync_fifo_flags. It holds count, computes the four status flags and the two sticky error flags from wr_acc/rd_acc, and is reused by the team's future width-converting FIFOs.
- Storage is a local register array with combinational read, registered in STD mode.

Test Plan:
- Fill, DWIDTH=8, DEPTH=5, AF_THRESH=3, FWFT=0. After reset, write 0x01..0x05 back-to-back. Then wr_almost_full=1 once count=3, and wr_full=1 with count=5 after the 5th write. A 6th write of 0xFF is dropped, wr_overflow=1 and stays 1.
- Drain, same configuration. Pulse rd_en 5 times: rd_data = 0x01..0x05, each one cycle after its rd_en, and rd_empty=1 after the 5th. A 6th rd_en gives rd_underflow=1 and rd_data holds 0x05.
- Wrap, DEPTH=5. Run 12 interleaved write/read pairs with data 0x10..0x1B. Output order equals input order, both pointers wrap 4 to 0, and count never exceeds 5.
- Simultaneous events:
  - at count=5, wr_en=rd_en=1: count becomes 4, head word popped, write discarded, wr_overflow=1
  - at count=2: count stays 2
  - at count=0: count becomes 1, rd_underflow=1
- FWFT=1. Write 0xA5 into an empty FIFO: the next cycle shows rd_empty=0 and rd_data=0xA5 with no rd_en. Write 0x5A, then rd_en for 1 cycle: rd_data=0x5A the next cycle, and a further rd_en gives rd_empty=1.
- Reset mid-operation. With count=3 and wr_overflow=1, assert rst for 1 cycle together with wr_en=1. The next cycle shows count=0, rd_empty=1, both error flags 0 and rd_data=0, and the concurrent write is ignored.
